// File: rtl/overcooked_pkg.sv
// Shared definitions for the kitchen grid: object codes, grid size defaults
// and the requester indices used by the grid write arbiter.
package overcooked_pkg;

    localparam int GRID_W_DEFAULT = 13;
    localparam int GRID_H_DEFAULT = 8;

    localparam logic [3:0] G_EMPTY        = 4'd0;
    localparam logic [3:0] G_ONION_WHOLE  = 4'd1;
    localparam logic [3:0] G_ONION_CHOP   = 4'd2;
    localparam logic [3:0] G_POT_EMPTY    = 4'd3;
    localparam logic [3:0] G_POT_COOKING  = 4'd4;
    localparam logic [3:0] G_POT_DONE     = 4'd5;
    localparam logic [3:0] G_POT_BURNT    = 4'd6;
    localparam logic [3:0] G_PLATE        = 4'd7;
    localparam logic [3:0] G_PLATE_SOUP   = 4'd8;
    localparam logic [3:0] G_FIRE         = 4'd9;
    localparam logic [3:0] G_EXTINGUISHER = 4'd10;

    typedef enum logic [1:0] {
        REQ_P1  = 2'd0,
        REQ_P2  = 2'd1,
        REQ_EVT = 2'd2
    } req_idx_e;

    function automatic logic in_grid(input logic [3:0] x, input logic [2:0] y,
                                     input int gw, input int gh);
        return (32'(x) < gw) && (32'(y) < gh);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick between the player slots; ptr_i names the slot
// that currently has first claim.
module rr_pick2 (
    input  logic occ0_i,
    input  logic occ1_i,
    input  logic ptr_i,
    output logic gnt_o
);

    always_comb begin
        gnt_o = ptr_i;
        if (ptr_i == 1'b0) begin
            gnt_o = (!occ0_i && occ1_i) ? 1'b1 : 1'b0;
        end else begin
            gnt_o = (!occ1_i && occ0_i) ? 1'b0 : 1'b1;
        end
    end

endmodule

// File: rtl/grid_write_arb.sv
// Arbitrates grid-cell writes from two players and the game-event source onto
// the single object_grid write port; same-cell losers are dropped.
module grid_write_arb
    import overcooked_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int GRID_W = GRID_W_DEFAULT,
    parameter int GRID_H = GRID_H_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0][3:0] req_x,
    input  logic [N_REQ-1:0][2:0] req_y,
    input  logic [N_REQ-1:0][3:0] req_obj,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  wr_en,
    output logic [3:0]            wr_x,
    output logic [2:0]            wr_y,
    output logic [3:0]            wr_obj,
    output logic [1:0]            wr_src,
    output logic [N_REQ-1:0]      conflict,
    output logic [N_REQ-1:0]      range_err
);

    localparam int EVT = int'(REQ_EVT);

    logic [N_REQ-1:0]      slot_vld_q, slot_vld_d;
    logic [N_REQ-1:0][3:0] slot_x_q, slot_x_d;
    logic [N_REQ-1:0][2:0] slot_y_q, slot_y_d;
    logic [N_REQ-1:0][3:0] slot_obj_q, slot_obj_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [3:0]            wr_x_q, wr_x_d;
    logic [2:0]            wr_y_q, wr_y_d;
    logic [3:0]            wr_obj_q, wr_obj_d;
    logic [1:0]            wr_src_q, wr_src_d;
    logic [N_REQ-1:0]      conflict_q, conflict_d;
    logic [N_REQ-1:0]      range_err_q, range_err_d;

    logic       rr_gnt;
    logic       gnt_vld;
    logic [1:0] gnt_idx;

    rr_pick2 u_rr_pick2 (
        .occ0_i (slot_vld_q[int'(REQ_P1)]),
        .occ1_i (slot_vld_q[int'(REQ_P2)]),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        gnt_vld = |slot_vld_q;
        gnt_idx = slot_vld_q[EVT] ? REQ_EVT : {1'b0, rr_gnt};
    end

    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_x_d    = slot_x_q;
        slot_y_d    = slot_y_q;
        slot_obj_d  = slot_obj_q;
        rr_ptr_d    = rr_ptr_q;
        wr_en_d     = 1'b0;
        wr_x_d      = wr_x_q;
        wr_y_d      = wr_y_q;
        wr_obj_d    = wr_obj_q;
        wr_src_d    = wr_src_q;
        conflict_d  = '0;
        range_err_d = '0;

        if (gnt_vld) begin
            slot_vld_d[gnt_idx] = 1'b0;
            wr_en_d  = 1'b1;
            wr_x_d   = slot_x_q[gnt_idx];
            wr_y_d   = slot_y_q[gnt_idx];
            wr_obj_d = slot_obj_q[gnt_idx];
            wr_src_d = gnt_idx;
            if (gnt_idx != REQ_EVT) begin
                rr_ptr_d = ~gnt_idx[0];
            end
            // First write to a cell wins; anyone else aiming at it loses the item.
            for (int j = 0; j < N_REQ; j++) begin
                if (2'(j) != gnt_idx && slot_vld_q[j] &&
                    slot_x_q[j] == slot_x_q[gnt_idx] &&
                    slot_y_q[j] == slot_y_q[gnt_idx]) begin
                    slot_vld_d[j] = 1'b0;
                    conflict_d[j] = 1'b1;
                end
            end
        end

        // Only empty slots accept, so a slot is never accepted and granted together.
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !slot_vld_q[i]) begin
                if (in_grid(req_x[i], req_y[i], GRID_W, GRID_H)) begin
                    slot_vld_d[i] = 1'b1;
                    slot_x_d[i]   = req_x[i];
                    slot_y_d[i]   = req_y[i];
                    slot_obj_d[i] = req_obj[i];
                end else begin
                    range_err_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            slot_vld_q  <= '0;
            slot_x_q    <= '0;
            slot_y_q    <= '0;
            slot_obj_q  <= '0;
            rr_ptr_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            wr_obj_q    <= '0;
            wr_src_q    <= '0;
            conflict_q  <= '0;
            range_err_q <= '0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_x_q    <= slot_x_d;
            slot_y_q    <= slot_y_d;
            slot_obj_q  <= slot_obj_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_x_q      <= wr_x_d;
            wr_y_q      <= wr_y_d;
            wr_obj_q    <= wr_obj_d;
            wr_src_q    <= wr_src_d;
            conflict_q  <= conflict_d;
            range_err_q <= range_err_d;
        end
    end

    assign req_ready = ~slot_vld_q;
    assign wr_en     = wr_en_q;
    assign wr_x      = wr_x_q;
    assign wr_y      = wr_y_q;
    assign wr_obj    = wr_obj_q;
    assign wr_src    = wr_src_q;
    assign conflict  = conflict_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_grid_write_arb.sv
// Directed bench for grid_write_arb: single write, priority, conflict, range,
// fairness and mid-operation reset.
module tb_grid_write_arb;

    logic            clk_in = 1'b0;
    logic            reset;
    logic [2:0]      req_valid;
    logic [2:0][3:0] req_x;
    logic [2:0][2:0] req_y;
    logic [2:0][3:0] req_obj;
    logic [2:0]      req_ready;
    logic            wr_en;
    logic [3:0]      wr_x;
    logic [2:0]      wr_y;
    logic [3:0]      wr_obj;
    logic [1:0]      wr_src;
    logic [2:0]      conflict;
    logic [2:0]      range_err;

    int n_pass = 0;
    int n_tot  = 0;
    int n_g0, n_g1;
    logic [1:0] exp_src;

    grid_write_arb dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_obj   (req_obj),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_obj    (wr_obj),
        .wr_src    (wr_src),
        .conflict  (conflict),
        .range_err (range_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_in();
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_obj   = '0;
    endtask

    task automatic set_req(input int i, input logic [3:0] x, input logic [2:0] y,
                           input logic [3:0] obj);
        req_valid[i] = 1'b1;
        req_x[i]     = x;
        req_y[i]     = y;
        req_obj[i]   = obj;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [1:0] src, input logic [3:0] x,
                          input logic [2:0] y, input logic [3:0] obj);
        chk({tag, "_en"},  32'(wr_en),  32'd1);
        chk({tag, "_src"}, 32'(wr_src), 32'(src));
        chk({tag, "_x"},   32'(wr_x),   32'(x));
        chk({tag, "_y"},   32'(wr_y),   32'(y));
        chk({tag, "_obj"}, 32'(wr_obj), 32'(obj));
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        step();
        step();
        chk("rst_wr_en",     32'(wr_en),     32'd0);
        chk("rst_conflict",  32'(conflict),  32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        chk("rst_wr_x",      32'(wr_x),      32'd0);
        chk("rst_wr_src",    32'(wr_src),    32'd0);

        // Single write
        reset = 1'b0;
        chk("first_ready", 32'(req_ready), 32'h7);
        set_req(0, 4'd3, 3'd2, 4'd1);
        step();
        clear_in();
        chk("single_c1_en",    32'(wr_en),     32'd0);
        chk("single_c1_ready", 32'(req_ready), 32'h6);
        step();
        chk_wr("single_c2", 2'd0, 4'd3, 3'd2, 4'd1);
        chk("single_c2_ready", 32'(req_ready), 32'h7);
        step();
        chk("single_c3_en", 32'(wr_en), 32'd0);

        // Priority: event, then P1, then P2
        do_reset();
        set_req(0, 4'd0, 3'd0, 4'd2);
        set_req(1, 4'd1, 3'd1, 4'd3);
        set_req(2, 4'd2, 3'd2, 4'd4);
        step();
        clear_in();
        chk("prio_c1_en", 32'(wr_en), 32'd0);
        step();
        chk_wr("prio_c2", 2'd2, 4'd2, 3'd2, 4'd4);
        step();
        chk_wr("prio_c3", 2'd0, 4'd0, 3'd0, 4'd2);
        step();
        chk_wr("prio_c4", 2'd1, 4'd1, 3'd1, 4'd3);
        step();
        chk("prio_c5_en", 32'(wr_en), 32'd0);

        // Player conflict on the same cell
        do_reset();
        set_req(0, 4'd5, 3'd4, 4'd5);
        set_req(1, 4'd5, 3'd4, 4'd6);
        step();
        clear_in();
        step();
        chk_wr("conf_c2", 2'd0, 4'd5, 3'd4, 4'd5);
        chk("conf_c2_conflict", 32'(conflict), 32'h2);
        step();
        chk("conf_c3_en",       32'(wr_en),     32'd0);
        chk("conf_c3_conflict", 32'(conflict),  32'd0);
        chk("conf_c3_ready",    32'(req_ready), 32'h7);

        // Event beats a player to the same cell
        do_reset();
        set_req(0, 4'd4, 3'd3, 4'd1);
        set_req(2, 4'd4, 3'd3, 4'd9);
        step();
        clear_in();
        step();
        chk_wr("evconf_c2", 2'd2, 4'd4, 3'd3, 4'd9);
        chk("evconf_c2_conflict", 32'(conflict), 32'h1);
        step();
        chk("evconf_c3_en", 32'(wr_en), 32'd0);

        // Out of range, then the far corner which is in range
        do_reset();
        set_req(2, 4'd13, 3'd0, 4'd9);
        step();
        clear_in();
        chk("range_c1_err",   32'(range_err), 32'h4);
        chk("range_c1_ready", 32'(req_ready), 32'h7);
        chk("range_c1_en",    32'(wr_en),     32'd0);
        step();
        chk("range_c2_err",   32'(range_err), 32'd0);
        chk("range_c2_en",    32'(wr_en),     32'd0);
        chk("range_c2_ready", 32'(req_ready), 32'h7);
        set_req(1, 4'd12, 3'd7, 4'd8);
        step();
        clear_in();
        chk("corner_c1_err", 32'(range_err), 32'd0);
        step();
        chk_wr("corner_c2", 2'd1, 4'd12, 3'd7, 4'd8);

        // Fairness: both players request continuously for 20 cycles
        do_reset();
        n_g0    = 0;
        n_g1    = 0;
        exp_src = 2'd0;
        set_req(0, 4'd1, 3'd0, 4'd2);
        set_req(1, 4'd1, 3'd1, 4'd3);
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c >= 2) begin
                chk($sformatf("fair_c%0d_en", c), 32'(wr_en), 32'd1);
                chk($sformatf("fair_c%0d_src", c), 32'(wr_src), 32'(exp_src));
                exp_src = exp_src ^ 2'd1;
            end
            if (wr_en && wr_src == 2'd0) n_g0++;
            if (wr_en && wr_src == 2'd1) n_g1++;
        end
        clear_in();
        chk("fair_n0", 32'(n_g0), 32'd10);
        chk("fair_n1", 32'(n_g1), 32'd9);

        // Reset during a grant cycle with all slots full
        do_reset();
        set_req(0, 4'd0, 3'd0, 4'd1);
        set_req(1, 4'd1, 3'd0, 4'd1);
        set_req(2, 4'd2, 3'd0, 4'd1);
        step();
        clear_in();
        chk("midrst_c1_ready", 32'(req_ready), 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_c2_en",       32'(wr_en),     32'd0);
        chk("midrst_c2_conflict", 32'(conflict),  32'd0);
        chk("midrst_c2_ready",    32'(req_ready), 32'h7);
        step();
        chk("midrst_c3_en",       32'(wr_en),    32'd0);
        chk("midrst_c3_conflict", 32'(conflict), 32'd0);
        step();
        chk("midrst_c4_en", 32'(wr_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
